// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and a debug/loader port.
// The CPU has priority; a wait counter bounds how long a pending debug request can be denied.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpuRead_i,
  input  logic              cpuWrite_i,
  input  logic [ADDR_W-1:0] cpuAddr_i,
  input  logic [DATA_W-1:0] cpuData_i,
  output logic [DATA_W-1:0] cpuData_o,
  output logic              cpuStall_o,
  input  logic              dbgReq_i,
  input  logic              dbgWe_i,
  input  logic [ADDR_W-1:0] dbgAddr_i,
  input  logic [DATA_W-1:0] dbgData_i,
  output logic              dbgGnt_o,
  output logic [DATA_W-1:0] dbgData_o,
  output logic              dbgValid_o,
  output logic              memRead_o,
  output logic              memWrite_o,
  output logic [ADDR_W-1:0] memAddr_o,
  output logic [DATA_W-1:0] memData_o,
  input  logic [DATA_W-1:0] memData_i,
  output logic [15:0]       stallCount_o
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic       cpu_req;
  logic       dbg_win;
  logic [3:0] wait_cnt;

  always_comb begin
    cpu_req    = cpuRead_i | cpuWrite_i;
    // Reset masks the grant so no memory access or stall leaks out while rst_i is high.
    dbg_win    = !rst_i && dbgReq_i && (!cpu_req || (wait_cnt == WAIT_LIMIT));

    memRead_o  = !rst_i && cpuRead_i;
    memWrite_o = !rst_i && cpuWrite_i;
    memAddr_o  = cpuAddr_i;
    memData_o  = cpuData_i;
    dbgGnt_o   = 1'b0;
    cpuStall_o = 1'b0;

    if (dbg_win) begin
      memRead_o  = !dbgWe_i;
      memWrite_o = dbgWe_i;
      memAddr_o  = dbgAddr_i;
      memData_o  = dbgData_i;
      dbgGnt_o   = 1'b1;
      cpuStall_o = cpu_req;
    end

    cpuData_o = memData_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (dbg_win) begin
      wait_cnt <= '0;
    end else if (dbgReq_i && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbgData_o  <= '0;
      dbgValid_o <= 1'b0;
    end else begin
      dbgValid_o <= dbg_win && !dbgWe_i;
      if (dbg_win && !dbgWe_i) begin
        dbgData_o <= memData_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCount_o <= '0;
    end else if (cpuStall_o && (stallCount_o != 16'hFFFF)) begin
      stallCount_o <= stallCount_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_valid;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stall_count;

  logic [31:0] mem [0:255];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpuRead_i(cpu_read), .cpuWrite_i(cpu_write), .cpuAddr_i(cpu_addr),
    .cpuData_i(cpu_wdata), .cpuData_o(cpu_rdata), .cpuStall_o(cpu_stall),
    .dbgReq_i(dbg_req), .dbgWe_i(dbg_we), .dbgAddr_i(dbg_addr), .dbgData_i(dbg_wdata),
    .dbgGnt_o(dbg_gnt), .dbgData_o(dbg_rdata), .dbgValid_o(dbg_valid),
    .memRead_o(mem_read), .memWrite_o(mem_write), .memAddr_o(mem_addr),
    .memData_o(mem_wdata), .memData_i(mem_rdata), .stallCount_o(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  typedef struct {
    string       name;
    logic        stall, gnt, valid, mrd, mwr;
    logic [31:0] maddr;
    logic [15:0] sc;
    logic        chk_dd;
    logic [31:0] dd;
    logic        chk_cd;
    logic [31:0] cd;
  } exp_t;

  exp_t expq[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void chk(string nm, string field, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk(e.name, "cpuStall", 32'(cpu_stall), 32'(e.stall));
      chk(e.name, "dbgGnt",   32'(dbg_gnt),   32'(e.gnt));
      chk(e.name, "dbgValid", 32'(dbg_valid), 32'(e.valid));
      chk(e.name, "memRead",  32'(mem_read),  32'(e.mrd));
      chk(e.name, "memWrite", 32'(mem_write), 32'(e.mwr));
      chk(e.name, "memAddr",  mem_addr,       e.maddr);
      chk(e.name, "stallCnt", 32'(stall_count), 32'(e.sc));
      if (e.chk_dd) chk(e.name, "dbgData", dbg_rdata, e.dd);
      if (e.chk_cd) chk(e.name, "cpuData", cpu_rdata, e.cd);
    end
  end

  task automatic step(input logic r, cr, cw, input logic [31:0] ca, cdin,
                      input logic dr, dwe, input logic [31:0] da, ddin,
                      input string nm, input logic e_stall, e_gnt, e_valid, e_mrd, e_mwr,
                      input logic [31:0] e_maddr, input logic [15:0] e_sc,
                      input logic c_dd, input logic [31:0] e_dd,
                      input logic c_cd, input logic [31:0] e_cd);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cdin;
    dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = ddin;
    e.name = nm; e.stall = e_stall; e.gnt = e_gnt; e.valid = e_valid;
    e.mrd = e_mrd; e.mwr = e_mwr; e.maddr = e_maddr; e.sc = e_sc;
    e.chk_dd = c_dd; e.dd = e_dd; e.chk_cd = c_cd; e.cd = e_cd;
    expq.push_back(e);
  endtask

  // CPU reads 0x10 every cycle while DBG writes 0x30: four denials, grant in cycle 4.
  task automatic round(input string nm, input logic [15:0] sc, input logic [31:0] wd);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h10, 0, 1, 1, 32'h30, wd, {nm, "_deny"},
           0, 0, 0, 1, 0, 32'h10, sc, 0, 0, 1, 32'hDEADBEEF);
    step(0, 1, 0, 32'h10, 0, 1, 1, 32'h30, wd, {nm, "_gnt"},
         1, 1, 0, 0, 1, 32'h30, sc, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    rst = 1'b1; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);

    // Requests while in reset must produce no access, grant or stall.
    step(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, "reset",
         0, 0, 0, 0, 0, 32'h10, 16'd0, 1, 32'h0, 0, 0);

    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, "cpu_alone",
         0, 0, 0, 1, 0, 32'h10, 16'd0, 0, 0, 1, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234, "dbg_wr",
         0, 1, 0, 0, 1, 32'h20, 16'd0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, "dbg_rd",
         0, 1, 0, 1, 0, 32'h20, 16'd0, 0, 0, 1, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "dbg_rd_data",
         0, 0, 1, 0, 0, 32'h0, 16'd0, 1, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "dbg_hold",
         0, 0, 0, 0, 0, 32'h0, 16'd0, 1, 32'h1234, 0, 0);

    round("cont", 16'd0, 32'hA5);

    // New DBG read the cycle after a grant: CPU wins, wait restarts from 0.
    step(0, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, "b2b_cpu",
         0, 0, 0, 1, 0, 32'h10, 16'd1, 0, 0, 1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, "b2b_deny",
           0, 0, 0, 1, 0, 32'h10, 16'd1, 0, 0, 1, 32'hDEADBEEF);
    step(0, 1, 0, 32'h10, 0, 1, 0, 32'h30, 0, "b2b_gnt",
         1, 1, 0, 1, 0, 32'h30, 16'd1, 0, 0, 1, 32'hA5);
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, "b2b_data",
         0, 0, 1, 1, 0, 32'h10, 16'd2, 1, 32'hA5, 1, 32'hDEADBEEF);

    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, "rst_mid_gnt",
         0, 1, 0, 1, 0, 32'h10, 16'd2, 0, 0, 1, 32'hDEADBEEF);
    #6 rst = 1'b1;
    step(1, 1, 0, 32'h10, 0, 1, 1, 32'h30, 32'hBAD, "rst_hold",
         0, 0, 0, 0, 0, 32'h10, 16'd0, 1, 32'h0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_release",
         0, 0, 0, 0, 0, 32'h0, 16'd0, 1, 32'h0, 0, 0);

    round("post_rst", 16'd0, 32'hA5);
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, "cpu_served",
         0, 0, 0, 1, 0, 32'h10, 16'd1, 0, 0, 1, 32'hDEADBEEF);

    // Jump the stall counter close to saturation instead of 65k contention rounds.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "preload",
         0, 0, 0, 0, 0, 32'h0, 16'hFFFE, 0, 0, 0, 0);
    #1 force dut.stallCount_o = 16'hFFFE;
    #1 release dut.stallCount_o;

    round("sat0", 16'hFFFE, 32'hA5);
    round("sat1", 16'hFFFF, 32'hA5);
    round("sat2", 16'hFFFF, 32'hA5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_hold",
         0, 0, 0, 0, 0, 32'h0, 16'hFFFF, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("drain", "pending", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing the single-port data memory between the pipeline's memory-access stage (CPU port) and a debug/loader port (DBG port). The CPU port has priority. A starvation counter guarantees the DBG port a grant after a bounded number of denied cycles. When the CPU loses arbitration, the arbiter stalls the pipeline. It sits between the memory stage and the DataMemory instance, replacing the direct connection. It also keeps a saturating count of CPU stall cycles for performance debug.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 4: maximum consecutive denied DBG cycles while the CPU requests. Legal range 1..15.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cpuRead_i` in 1: CPU load request (memory-stage read enable).
- `cpuWrite_i` in 1: CPU store request.
- `cpuAddr_i` in ADDR_W: CPU address.
- `cpuData_i` in DATA_W: CPU store data.
- `cpuData_o` out DATA_W: CPU load data.
- `cpuStall_o` out 1: pipeline must hold the memory stage and all earlier stages this cycle.
- `dbgReq_i` in 1: DBG request; held until granted.
- `dbgWe_i` in 1: DBG request is a write (1) or a read (0).
- `dbgAddr_i` in ADDR_W: DBG address.
- `dbgData_i` in DATA_W: DBG write data.
- `dbgGnt_o` out 1: DBG access performed this cycle.
- `dbgData_o` out DATA_W: DBG read data, registered.
- `dbgValid_o` out 1: one-cycle pulse; `dbgData_o` is valid.
- `memRead_o` out 1: memory read enable.
- `memWrite_o` out 1: memory write enable.
- `memAddr_o` out ADDR_W: memory address.
- `memData_o` out DATA_W: memory write data.
- `memData_i` in DATA_W: memory read data (combinational memory).
- `stallCount_o` out 16: saturating count of cycles with `cpuStall_o`=1.

## Operation
- `cpuReq` = `cpuRead_i` | `cpuWrite_i`.
- Grant decision is combinational from the current requests and the registered `waitCnt`:
  - `dbgWin` = `dbgReq_i` & (!`cpuReq` | `waitCnt` == `MAX_WAIT`).
  - `cpuGnt` = `cpuReq` & !`dbgWin`.
- DBG granted (`dbgWin`):
  - `dbgGnt_o`=1.
  - `memAddr_o`=`dbgAddr_i`, `memData_o`=`dbgData_i`.
  - `memWrite_o`=`dbgWe_i`, `memRead_o`=!`dbgWe_i`.
  - `cpuStall_o`=`cpuReq`.
- Otherwise:
  - Memory driven from the CPU port: `memRead_o`=`cpuRead_i`, `memWrite_o`=`cpuWrite_i`, `memAddr_o`=`cpuAddr_i`, `memData_o`=`cpuData_i`.
  - `cpuStall_o`=0, `dbgGnt_o`=0.
- `cpuData_o`=`memData_i` at all times. It is meaningful only in a cycle where `cpuGnt` & `cpuRead_i`.
- `waitCnt` (4 bits):
  - Resets to 0.
  - Cleared on any cycle with `dbgGnt_o`=1.
  - Increments on a cycle with `dbgReq_i`=1 & `dbgGnt_o`=0.
  - Holds on a cycle with `dbgReq_i`=0. Never exceeds `MAX_WAIT`.
- DBG handshake:
  - The requester holds `dbgReq_i`, `dbgWe_i`, `dbgAddr_i` and `dbgData_i` stable until it samples `dbgGnt_o`=1.
  - A new request may be presented in the next cycle. Because `waitCnt` restarts at 0, the CPU wins that cycle if it is requesting.
- DBG read capture: on a DBG read grant, `dbgData_o` <= `memData_i` and `dbgValid_o` <= 1 at the clock edge.
  - `dbgValid_o` is 0 in all other cycles.
  - `dbgData_o` holds its value until the next DBG read.
- `stallCount_o` increments on each edge where `cpuStall_o`=1. It saturates at 0xFFFF and is cleared only by reset.
- While `rst_i`=1:
  - All memory enables are 0.
  - `dbgGnt_o`=0 and `cpuStall_o`=0.
  - Registered outputs are held at their reset values.

## Timing
- Reset values: `waitCnt`=0, `dbgData_o`=0, `dbgValid_o`=0, `stallCount_o`=0.
- Reset is asynchronous. Asserting it mid-DBG-read cancels the pending `dbgValid_o` pulse; no valid pulse follows deassertion.
- CPU access latency is 0 cycles: load data arrives the same cycle and stores are written at the edge ending the granted cycle.
- DBG write latency is 0 cycles after grant.
- DBG read data is visible 1 cycle after the grant cycle, together with `dbgValid_o`.
- Worst-case DBG wait under continuous CPU traffic is `MAX_WAIT` cycles, with the grant in cycle `MAX_WAIT` (0-based).
- A stall lasts exactly 1 cycle per DBG grant.
- Simultaneous CPU and DBG requests with `waitCnt` < `MAX_WAIT`: the CPU wins and `waitCnt` increments.
- CPU idle: a DBG request is granted in the same cycle it is presented, regardless of `waitCnt`.

## Test plan
- Reset mid-operation:
  - Stimulus: DBG read granted, `rst_i` asserted before the next edge.
  - Required: `dbgValid_o` stays 0, `stallCount_o`=0, `waitCnt`=0 after release.
- CPU alone:
  - Stimulus: memory word 0x10 = 0xDEADBEEF; `cpuRead_i`=1, `cpuAddr_i`=0x10.
  - Required: `cpuData_o`=0xDEADBEEF the same cycle, `cpuStall_o`=0, `memRead_o`=1.
- DBG alone:
  - Stimulus: write 0x1234 to 0x20 with the CPU idle, then read 0x20.
  - Required: `dbgGnt_o`=1 in each request cycle; `dbgValid_o`=1 with `dbgData_o`=0x1234 one cycle after the read grant.
- Contention:
  - Stimulus: `MAX_WAIT`=4; CPU requests every cycle; `dbgReq_i` held from cycle 0.
  - Required: denied in cycles 0–3; `dbgGnt_o`=1 and `cpuStall_o`=1 only in cycle 4; CPU served again in cycle 5; `stallCount_o`=1.
- Saturation:
  - Stimulus: `stallCount_o` preloaded to 0xFFFE by repeated contention, then 3 more stall cycles.
  - Required: `stallCount_o` reads 0xFFFF and stays there.
- Back-to-back DBG:
  - Stimulus: CPU requesting; second DBG request presented the cycle after a grant.
  - Required: the CPU wins that cycle; the DBG wait restarts from 0.
